// File: rtl/global_control_pkg.sv
// global_control_pkg: types shared by the sequencer, the cell cores and the grid.
//   pc_t           program-memory address (256 words)
//   sp_t           return-stack pointer (16 entries)
//   opcode_t       control-flow opcodes plus the cell operations
//   instruction_t  broadcast instruction word {opcode, target}
//   state_t        sequencer state
package global_control_pkg;

  localparam int unsigned PC_W = 8;
  localparam int unsigned SP_W = 4;

  typedef logic [PC_W-1:0] pc_t;
  typedef logic [SP_W-1:0] sp_t;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_JMP   = 4'd1,
    OP_BRC   = 4'd2,
    OP_CALL  = 4'd3,
    OP_RET   = 4'd4,
    OP_HALT  = 4'd5,
    OP_ADD   = 4'd6,
    OP_SUB   = 4'd7,
    OP_AND   = 4'd8,
    OP_OR    = 4'd9,
    OP_XOR   = 4'd10,
    OP_SHL   = 4'd11,
    OP_SHR   = 4'd12,
    OP_LOAD  = 4'd13,
    OP_STORE = 4'd14,
    OP_SWAP  = 4'd15
  } opcode_t;

  typedef struct packed {
    opcode_t opcode;
    pc_t     target;
  } instruction_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  // Sequential successor; wraps from the last program word back to 0.
  function automatic pc_t pc_inc(input pc_t pc);
    return pc + 1'b1;
  endfunction

endpackage

// File: rtl/global_control_if.sv
// global_control_if: broadcast bus between the sequencer and the cell grid.
//   instruction           issued instruction word
//   next_program_counter  PC after the issued instruction
//   next_stack_pointer    SP after the issued instruction
//   global_enable         one-cycle issue strobe
//   diverge_consensus     AND of all cores' diverge flags (grid -> sequencer)
// master: sequencer side; slave: grid side.
interface global_control_if;
  import global_control_pkg::*;

  instruction_t instruction;
  pc_t          next_program_counter;
  sp_t          next_stack_pointer;
  logic         global_enable;
  logic         diverge_consensus;

  modport master (
    output instruction,
    output next_program_counter,
    output next_stack_pointer,
    output global_enable,
    input  diverge_consensus
  );

  modport slave (
    input  instruction,
    input  next_program_counter,
    input  next_stack_pointer,
    input  global_enable,
    output diverge_consensus
  );
endinterface

// File: rtl/global_control_return_stack.sv
// return_stack: STACK_DEPTH x pc_t return-address RAM with a registered pointer.
//   clk, rst    clock, synchronous active-high reset (pointer only)
//   clear       reset pointer to 0 (execution start)
//   push        write push_data at stack[sp], sp+1
//   pop         sp-1
//   sp          current stack pointer
//   top         stack[sp-1], the address a RET returns to
//   overflow    sp == STACK_DEPTH-1 (a further push is refused by the caller)
//   underflow   sp == 0
// The RAM contents are never cleared.
module return_stack
  import global_control_pkg::*;
#(
  parameter int unsigned STACK_DEPTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic push,
  input  logic pop,
  input  pc_t  push_data,
  output sp_t  sp,
  output pc_t  top,
  output logic overflow,
  output logic underflow
);

  pc_t mem [STACK_DEPTH];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[sp] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sp <= '0;
    end else if (push) begin
      sp <= sp + 1'b1;
    end else if (pop) begin
      sp <= sp - 1'b1;
    end
  end

  assign top       = mem[sp - 1'b1];
  assign overflow  = (sp == sp_t'(STACK_DEPTH - 1));
  assign underflow = (sp == '0);

endmodule

// File: rtl/global_control.sv
// global_control: program sequencer driving the cell grid's broadcast bus.
// Holds program memory, PC and return stack; fetches each word, then issues
// it to all cores with a one-cycle global_enable (one instruction per 2 cycles).
//   clk, rst             clock, synchronous active-high reset
//   prog_we/addr/wdata   program-memory write port (honoured in IDLE/HALT only)
//   start                begin execution at address 0 (honoured in IDLE/HALT only)
//   bus (master)         instruction, next_program_counter, next_stack_pointer,
//                        global_enable out; diverge_consensus in
//   running              high in FETCH/ISSUE
//   halted               high in HALT
//   fault                sticky stack overflow/underflow
//   issue_count          (GLOBAL_CONTROL_ISSUE_COUNT_EN only) count of issue strobes
module global_control
  import global_control_pkg::*;
#(
  parameter int unsigned PROG_DEPTH  = 256,
  parameter int unsigned STACK_DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             prog_we,
  input  pc_t              prog_addr,
  input  instruction_t     prog_wdata,
  input  logic             start,
  global_control_if.master bus,
  output logic             running,
  output logic             halted,
  output logic             fault
`ifdef GLOBAL_CONTROL_ISSUE_COUNT_EN
  ,
  output logic [31:0]      issue_count
`endif
);

  state_t       state;
  pc_t          pc;
  instruction_t instr_q;
  pc_t          npc_q;
  sp_t          nsp_q;
  instruction_t prog_mem [PROG_DEPTH];

  logic idle_like;
  logic start_ok;
  logic issuing;

  sp_t  sp;
  pc_t  stk_top;
  logic stk_overflow;
  logic stk_underflow;

  pc_t  npc;
  sp_t  nsp;
  logic push;
  logic pop;
  logic halt_hit;
  logic fault_hit;
  logic ge;

  assign idle_like = (state == ST_IDLE) || (state == ST_HALT);
  assign start_ok  = idle_like && start;
  assign issuing   = (state == ST_ISSUE);

  always_ff @(posedge clk) begin
    if (prog_we && idle_like && !rst) begin
      prog_mem[prog_addr] <= prog_wdata;
    end
  end

  return_stack #(
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .clear     (start_ok),
    .push      (push && !rst),
    .pop       (pop && !rst),
    .push_data (pc_inc(pc)),
    .sp        (sp),
    .top       (stk_top),
    .overflow  (stk_overflow),
    .underflow (stk_underflow)
  );

  // Control-flow resolution for the word held in instr_q; only meaningful in ISSUE.
  // Faulting CALL/RET and HALT keep pc/sp where they are.
  always_comb begin
    npc       = pc_inc(pc);
    nsp       = sp;
    push      = 1'b0;
    pop       = 1'b0;
    halt_hit  = 1'b0;
    fault_hit = 1'b0;
    case (instr_q.opcode)
      OP_JMP: npc = instr_q.target;
      OP_BRC: begin
        if (bus.diverge_consensus) begin
          npc = instr_q.target;
        end
      end
      OP_CALL: begin
        if (stk_overflow) begin
          fault_hit = 1'b1;
          npc       = pc;
        end else begin
          push = 1'b1;
          nsp  = sp + 1'b1;
          npc  = instr_q.target;
        end
      end
      OP_RET: begin
        if (stk_underflow) begin
          fault_hit = 1'b1;
          npc       = pc;
        end else begin
          pop = 1'b1;
          nsp = sp - 1'b1;
          npc = stk_top;
        end
      end
      OP_HALT: begin
        halt_hit = 1'b1;
        npc      = pc;
      end
      default: ;
    endcase
    if (!issuing) begin
      push      = 1'b0;
      pop       = 1'b0;
      halt_hit  = 1'b0;
      fault_hit = 1'b0;
    end
  end

  assign ge = issuing && !halt_hit && !fault_hit;

  // instr_q is the synchronous read register of the program RAM; it only loads
  // in FETCH, so it also holds the last issued word outside ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      pc          <= '0;
      fault       <= 1'b0;
      instr_q     <= '0;
      npc_q       <= '0;
      nsp_q       <= '0;
`ifdef GLOBAL_CONTROL_ISSUE_COUNT_EN
      issue_count <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_HALT: begin
          if (start) begin
            pc          <= '0;
            fault       <= 1'b0;
            state       <= ST_FETCH;
`ifdef GLOBAL_CONTROL_ISSUE_COUNT_EN
            issue_count <= '0;
`endif
          end
        end
        ST_FETCH: begin
          instr_q <= prog_mem[pc];
          state   <= ST_ISSUE;
        end
        ST_ISSUE: begin
          pc    <= npc;
          npc_q <= npc;
          nsp_q <= nsp;
          if (fault_hit) begin
            fault <= 1'b1;
            state <= ST_HALT;
          end else if (halt_hit) begin
            state <= ST_HALT;
          end else begin
            state <= ST_FETCH;
          end
`ifdef GLOBAL_CONTROL_ISSUE_COUNT_EN
          if (ge) begin
            issue_count <= issue_count + 32'd1;
          end
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.instruction          = instr_q;
  assign bus.next_program_counter = issuing ? npc : npc_q;
  assign bus.next_stack_pointer   = issuing ? nsp : nsp_q;
  assign bus.global_enable        = ge;

  assign running = (state == ST_FETCH) || (state == ST_ISSUE);
  assign halted  = (state == ST_HALT);

endmodule

// File: tb/tb_global_control.sv
// tb_global_control: randomized and directed programs for global_control.
// An interpreter of the instruction set predicts every issued word, its
// successor PC/SP and its cycle offset from start; a monitor checks each
// global_enable strobe against that scoreboard.
module tb_global_control;
  import global_control_pkg::*;

  localparam int SDEPTH = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         prog_we;
  pc_t          prog_addr;
  instruction_t prog_wdata;
  logic         start;
  logic         running;
  logic         halted;
  logic         fault;
`ifdef GLOBAL_CONTROL_ISSUE_COUNT_EN
  logic [31:0]  issue_count;
`endif

  global_control_if bus ();

  global_control #(
    .PROG_DEPTH  (256),
    .STACK_DEPTH (SDEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_wdata  (prog_wdata),
    .start       (start),
    .bus         (bus),
    .running     (running),
    .halted      (halted),
    .fault       (fault)
`ifdef GLOBAL_CONTROL_ISSUE_COUNT_EN
    ,
    .issue_count (issue_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    instruction_t instr;
    pc_t          npc;
    sp_t          nsp;
    int           off;
  } exp_t;

  exp_t         sb[$];
  exp_t         mq[$];
  instruction_t prog [256];
  bit           dcpat [256];
  int           start_cyc = 0;
  int           checks = 0;
  int           passed = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endfunction

  function automatic instruction_t mk(input opcode_t op, input int t);
    instruction_t w;
    w.opcode = op;
    w.target = pc_t'(t);
    return w;
  endfunction

  // Instruction-set interpreter. Issue k happens 2+2k cycles after start.
  // Returns 1 if the program stops (HALT or stack fault) within 60 issues.
  function automatic bit model(output bit flt);
    int           pc;
    int           npc;
    int           stk[$];
    instruction_t w;
    bit           d;
    mq.delete();
    flt = 1'b0;
    pc  = 0;
    for (int k = 0; k < 60; k++) begin
      w = prog[pc];
      d = dcpat[(2 + 2 * k) % 256];
      case (w.opcode)
        OP_HALT: return 1'b1;
        OP_JMP:  npc = int'(w.target);
        OP_BRC:  npc = d ? int'(w.target) : (pc + 1) % 256;
        OP_CALL: begin
          if (stk.size() == SDEPTH - 1) begin
            flt = 1'b1;
            return 1'b1;
          end
          stk.push_back((pc + 1) % 256);
          npc = int'(w.target);
        end
        OP_RET: begin
          if (stk.size() == 0) begin
            flt = 1'b1;
            return 1'b1;
          end
          npc = stk.pop_back();
        end
        default: npc = (pc + 1) % 256;
      endcase
      mq.push_back('{w, pc_t'(npc), sp_t'(stk.size()), 2 + 2 * k});
      pc = npc;
    end
    return 1'b0;
  endfunction

  // Monitor: every issue strobe must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.global_enable === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_issue: got instr %0h npc %0h, expected no issue (t=%0t)",
                   bus.instruction, bus.next_program_counter, $time);
        end else begin
          e = sb.pop_front();
          chk("instruction", bus.instruction, e.instr);
          chk("next_program_counter", bus.next_program_counter, e.npc);
          chk("next_stack_pointer", bus.next_stack_pointer, e.nsp);
          chk("issue_cycle", cyc - start_cyc + 1, e.off);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input instruction_t w);
    prog_we    = 1'b1;
    prog_addr  = pc_t'(a);
    prog_wdata = w;
    tick();
    prog_we = 1'b0;
    prog[a] = w;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_instruction"}, bus.instruction, 0);
    chk({tag, "_npc"}, bus.next_program_counter, 0);
    chk({tag, "_nsp"}, bus.next_stack_pointer, 0);
    chk({tag, "_global_enable"}, bus.global_enable, 0);
    chk({tag, "_running"}, running, 0);
    chk({tag, "_halted"}, halted, 0);
    chk({tag, "_fault"}, fault, 0);
  endtask

  // abort_c>0 asserts rst during that cycle; disturb pokes prog_we/start mid-run;
  // wr0 writes w0 to address 0 in the same cycle as start.
  task automatic run(input int abort_c, input bit disturb, input bit wr0, input instruction_t w0);
    bit term, flt, done;
    int n;
    if (wr0) prog[0] = w0;
    term = model(flt);
    n    = mq.size();
    if (!term) $display("note: program did not terminate in model");
    foreach (mq[i]) sb.push_back(mq[i]);
    start = 1'b1;
    if (wr0) begin
      prog_we    = 1'b1;
      prog_addr  = '0;
      prog_wdata = w0;
    end
    tick();
    start     = 1'b0;
    prog_we   = 1'b0;
    start_cyc = cyc;
    done      = 1'b0;
    for (int c = 1; c < 400 && !done; c++) begin
      bus.diverge_consensus = dcpat[c % 256];
      if (disturb && c == 3) begin
        prog_we    = 1'b1;
        prog_addr  = pc_t'(3);
        prog_wdata = mk(OP_HALT, 0);
        start      = 1'b1;
      end else begin
        prog_we = 1'b0;
        start   = 1'b0;
      end
      if (c == abort_c) rst = 1'b1;
      tick();
      if (rst) begin
        rst = 1'b0;
        check_zero("abort");
        sb.delete();
        return;
      end
      if (halted) done = 1'b1;
    end
    prog_we = 1'b0;
    start   = 1'b0;
    chk("halt_reached", done, 1);
    chk("fault", fault, flt);
    chk("running_after_halt", running, 0);
    chk("pending_issues", sb.size(), 0);
`ifdef GLOBAL_CONTROL_ISSUE_COUNT_EN
    chk("issue_count", issue_count, n);
`endif
    if (n < 0) $display("note: negative count");
    sb.delete();
    if (!done) begin
      rst = 1'b1;
      tick();
      rst = 1'b0;
    end
  endtask

  function automatic instruction_t rand_instr();
    int r, v, t;
    r = $urandom_range(0, 99);
    t = $urandom_range(0, 31);
    if (r < 35) begin
      v = $urandom_range(0, 10);
      return mk((v == 0) ? OP_NOP : opcode_t'(v + 5), t);
    end
    if (r < 45) return mk(OP_JMP, t);
    if (r < 62) return mk(OP_BRC, t);
    if (r < 77) return mk(OP_CALL, t);
    if (r < 90) return mk(OP_RET, t);
    return mk(OP_HALT, t);
  endfunction

  initial begin
    bit           flt, ok, wr0;
    instruction_t w0;
    rst        = 1'b1;
    start      = 1'b0;
    prog_we    = 1'b0;
    prog_addr  = '0;
    prog_wdata = '0;
    bus.diverge_consensus = 1'b0;
    foreach (dcpat[i]) dcpat[i] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    for (int a = 0; a < 256; a++) load(a, mk(OP_HALT, 0));

    // Straight-line: NOP, NOP, HALT
    load(0, mk(OP_NOP, 0));
    load(1, mk(OP_NOP, 0));
    load(2, mk(OP_HALT, 0));
    run(0, 1'b0, 1'b0, '0);

    // Consensus branch taken / not taken
    load(0, mk(OP_BRC, 5));
    load(1, mk(OP_HALT, 0));
    load(5, mk(OP_HALT, 0));
    foreach (dcpat[i]) dcpat[i] = 1'b1;
    run(0, 1'b0, 1'b0, '0);
    foreach (dcpat[i]) dcpat[i] = 1'b0;
    run(0, 1'b0, 1'b0, '0);

    // Branch must use the ISSUE-cycle consensus only
    foreach (dcpat[i]) dcpat[i] = (i % 2 == 1);
    run(0, 1'b0, 1'b0, '0);
    foreach (dcpat[i]) dcpat[i] = 1'b0;

    // Call / return
    load(0, mk(OP_CALL, 10));
    load(1, mk(OP_HALT, 0));
    load(10, mk(OP_RET, 0));
    run(0, 1'b0, 1'b0, '0);

    // Self-recursion overflows after STACK_DEPTH-1 calls
    load(0, mk(OP_CALL, 0));
    run(0, 1'b0, 1'b0, '0);

    // Return with empty stack, then a clean run clears fault
    load(0, mk(OP_RET, 0));
    run(0, 1'b0, 1'b0, '0);
    load(0, mk(OP_NOP, 0));
    run(0, 1'b0, 1'b0, '0);

    // PC wrap from 255 to 0
    load(0, mk(OP_BRC, 255));
    load(255, mk(OP_NOP, 0));
    load(1, mk(OP_HALT, 0));
    dcpat[2] = 1'b1;
    run(0, 1'b0, 1'b0, '0);
    dcpat[2] = 1'b0;

    // Writes and start while running are ignored; rerun without reload
    for (int a = 0; a < 6; a++) load(a, mk(OP_ADD, a));
    load(6, mk(OP_HALT, 0));
    run(0, 1'b1, 1'b0, '0);
    run(0, 1'b0, 1'b0, '0);

    // Reset during ISSUE, then rerun the retained program
    run(4, 1'b0, 1'b0, '0);
    run(0, 1'b0, 1'b0, '0);

    // Random programs over addresses 0..31
    for (int t = 0; t < 20; t++) begin
      foreach (dcpat[i]) dcpat[i] = 1'($urandom_range(0, 1));
      ok = 1'b0;
      for (int tries = 0; tries < 100 && !ok; tries++) begin
        for (int a = 0; a < 32; a++) prog[a] = rand_instr();
        ok = model(flt);
      end
      if (!ok) prog[0] = mk(OP_HALT, 0);
      w0  = prog[0];
      wr0 = 1'($urandom_range(0, 1));
      for (int a = 1; a < 32; a++) load(a, prog[a]);
      if (wr0) load(0, mk(OP_HALT, 0));
      else     load(0, w0);
      run(0, 1'b0, wr0, w0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
